tile_ram_arbiter: RTL

Shares the single-port tile RAM between the VGA scan-out path and the snake game logic. It sits between the VGA timing and pixel pipeline and the RAM macro. Video tile reads always win. Game writes are absorbed by a small write queue and drained into free RAM cycles. Game reads are issued only after the queue has drained, so they always return the latest written data.

---
 rtl/tile_ram_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/tile_ram_arbiter.sv
// ============================================================================
//  Module   : tile_ram_arbiter
//  Purpose  : Shares the single-port tile RAM between VGA scan-out reads and
//             snake game reads/writes; game writes are buffered in a small
//             queue and drained into free RAM cycles.
//  Options  : TILE_ARB_STATS_EN builds the saturating write-stall counter.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tile_ram_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 4,
    parameter int WQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vid_rd_req,
    input  logic [ADDR_W-1:0]         vid_rd_addr,
    output logic                      vid_rd_valid,
    output logic [DATA_W-1:0]         vid_rd_data,
    input  logic                      game_wr_req,
    input  logic [ADDR_W-1:0]         game_wr_addr,
    input  logic [DATA_W-1:0]         game_wr_data,
    output logic                      game_wr_ack,
    input  logic                      game_rd_req,
    input  logic [ADDR_W-1:0]         game_rd_addr,
    output logic                      game_rd_gnt,
    output logic                      game_rd_valid,
    output logic [DATA_W-1:0]         game_rd_data,
    output logic [$clog2(WQ_DEPTH):0] wq_count,
    output logic                      wq_full,
    output logic [15:0]               stall_count,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_WR   = 2'd2,
        GNT_GRD  = 2'd3
    } gnt_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_VID  = 2'b01,
        TAG_GAME = 2'b10
    } tag_e;

    logic [ADDR_W-1:0] wq_addr_q [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data_q [WQ_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    gnt_e              gnt_d;
    tag_e              tag_q, tag_d, tag2_q;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              gnt_q, gnt_d_pulse;
    logic [DATA_W-1:0] vid_data_q, game_data_q;
    logic              push, pop, grd_busy;

    assign wq_full     = (count_q == CNT_W'(WQ_DEPTH));
    assign game_wr_ack = game_wr_req & ~wq_full;
    assign push        = game_wr_ack;
    assign pop         = (gnt_d == GNT_WR);
    // A game read is in flight from its RAM cycle until its data returns.
    assign grd_busy    = gnt_q | (tag2_q == TAG_GAME);

    always_comb begin
        gnt_d = GNT_IDLE;
        if (vid_rd_req) begin
            gnt_d = GNT_VID;
        end else if (count_q != '0) begin
            gnt_d = GNT_WR;
        end else if (game_rd_req && !game_wr_ack && !grd_busy) begin
            // A write acked this very cycle must land before the read.
            gnt_d = GNT_GRD;
        end
    end

    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        tag_d       = TAG_NONE;
        gnt_d_pulse = 1'b0;
        case (gnt_d)
            GNT_VID: begin
                ram_en_d   = 1'b1;
                ram_addr_d = vid_rd_addr;
                tag_d      = TAG_VID;
            end
            GNT_WR: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = wq_addr_q[head_q];
                ram_wdata_d = wq_data_q[head_q];
            end
            GNT_GRD: begin
                ram_en_d    = 1'b1;
                ram_addr_d  = game_rd_addr;
                tag_d       = TAG_GAME;
                gnt_d_pulse = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wq_addr_q[tail_q] <= game_wr_addr;
            wq_data_q[tail_q] <= game_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            gnt_q       <= 1'b0;
            tag_q       <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            vid_data_q  <= '0;
            game_data_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            gnt_q       <= gnt_d_pulse;
            tag_q       <= tag_d;
            tag2_q      <= tag_q;
            vid_data_q  <= vid_rd_data;
            game_data_q <= game_rd_data;
        end
    end

    // RAM data arrives the cycle after the access; the idle source holds.
    assign vid_rd_valid  = (tag2_q == TAG_VID);
    assign game_rd_valid = (tag2_q == TAG_GAME);
    assign vid_rd_data   = vid_rd_valid  ? ram_rdata : vid_data_q;
    assign game_rd_data  = game_rd_valid ? ram_rdata : game_data_q;

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign game_rd_gnt = gnt_q;
    assign wq_count    = count_q;

`ifdef TILE_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (game_wr_req && wq_full && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'd0;
`endif

endmodule

`default_nettype wire
